// File: rtl/ctrl_tag_alloc.sv
// ctrl_tag_alloc: branch checkpoint tag allocator backed by a circular free-tag FIFO.
// Define CTRL_TAG_ALLOC_CHECK_EN to enable the sticky protocol checker on error_o.
module ctrl_tag_alloc #(
    parameter int NUM_TAGS       = 8,
    parameter int TAG_LOG        = 3,
    parameter int DISPATCH_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush_i,
    input  logic                      instBufferReady_i,
    input  logic                      stall_i,
    input  logic [DISPATCH_WIDTH-1:0] branchVector_i,
    input  logic [2:0]                branchCount_i,
    input  logic                      resolveValid_i,
    input  logic [TAG_LOG-1:0]        resolveTag_i,
    output logic                      groupValid_o,
    output logic [TAG_LOG-1:0]        tag0_o,
    output logic [TAG_LOG-1:0]        tag1_o,
    output logic [TAG_LOG-1:0]        tag2_o,
    output logic [TAG_LOG-1:0]        tag3_o,
    output logic [DISPATCH_WIDTH-1:0] tagValid_o,
    output logic                      stallTag_o,
    output logic [TAG_LOG:0]          freeCount_o,
    output logic                      error_o
);
    localparam logic [TAG_LOG:0] FULL = (TAG_LOG+1)'(NUM_TAGS);

    logic [TAG_LOG-1:0] fifo [NUM_TAGS];
    logic [TAG_LOG-1:0] head, tail;
    logic [TAG_LOG:0]   count, n;
    logic [TAG_LOG-1:0] slot_tag [DISPATCH_WIDTH];
    logic [TAG_LOG-1:0] tag_q [DISPATCH_WIDTH];
    logic               alloc, rel;

    // Running popcount doubles as each branch slot's offset from the head.
    always_comb begin
        n = '0;
        for (int i = 0; i < DISPATCH_WIDTH; i++) begin
            slot_tag[i] = branchVector_i[i] ? fifo[head + n[TAG_LOG-1:0]] : '0;
            n = n + (TAG_LOG+1)'(branchVector_i[i]);
        end
    end

    assign alloc       = instBufferReady_i & ~stall_i & ~flush_i & (count >= n);
    assign rel         = resolveValid_i & ~flush_i & (count != FULL);
    assign stallTag_o  = instBufferReady_i & ~stall_i & (count < n);
    assign freeCount_o = count;
    assign tag0_o      = tag_q[0];
    assign tag1_o      = tag_q[1];
    assign tag2_o      = tag_q[2];
    assign tag3_o      = tag_q[3];

    // Allocation reads pre-edge contents, so a tag released this cycle is never reissued in it.
    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            for (int k = 0; k < NUM_TAGS; k++) fifo[k] <= TAG_LOG'(k);
            head         <= '0;
            tail         <= '0;
            count        <= FULL;
            groupValid_o <= 1'b0;
            tagValid_o   <= '0;
        end else begin
            if (rel) begin
                fifo[tail] <= resolveTag_i;
                tail       <= tail + 1'b1;
            end
            if (alloc) head <= head + n[TAG_LOG-1:0];
            count        <= count - (alloc ? n : '0) + (TAG_LOG+1)'(rel);
            groupValid_o <= alloc;
            tagValid_o   <= alloc ? branchVector_i : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DISPATCH_WIDTH; i++) tag_q[i] <= '0;
        end else if (alloc) begin
            for (int i = 0; i < DISPATCH_WIDTH; i++) tag_q[i] <= slot_tag[i];
        end
    end

`ifdef CTRL_TAG_ALLOC_CHECK_EN
    always_ff @(posedge clk) begin
        if (reset) error_o <= 1'b0;
        else if ((resolveValid_i & ~flush_i & (count == FULL)) |
                 (alloc & (32'(branchCount_i) != 32'(n)))) error_o <= 1'b1;
    end
`else
    logic unused_count;
    assign unused_count = ^branchCount_i;
    assign error_o      = 1'b0;
`endif
endmodule

// File: doc/ctrl_tag_alloc.md
CTRL_TAG_ALLOC -- requirements
Module: ctrl_tag_alloc

Interface
REQ-001 SHALL have parameter NUM_TAGS, default 8: number of branch checkpoint tags; power of two.
REQ-002 SHALL have parameter TAG_LOG, default 3: log2(NUM_TAGS).
REQ-003 SHALL have parameter DISPATCH_WIDTH, default 4: number of dispatch slots per group.
REQ-004 SHALL have port clk, input, 1: clock; all state updates on the rising edge.
REQ-005 SHALL have port reset, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port flush_i, input, 1: control mispredict; return all tags to the free list.
REQ-007 SHALL have port instBufferReady_i, input, 1: instruction buffer holds a full dispatch group.
REQ-008 SHALL have port stall_i, input, 1: backend stall; no group consumed.
REQ-009 SHALL have port branchVector_i, input, DISPATCH_WIDTH: per-slot branch flag of the head group.
REQ-010 SHALL have port branchCount_i, input, 3: branch count of the head group, supplied by the instruction buffer.
REQ-011 SHALL have port resolveValid_i, input, 1: one branch resolved this cycle; its tag is released.
REQ-012 SHALL have port resolveTag_i, input, TAG_LOG: tag being released.
REQ-013 SHALL have port groupValid_o, output, 1: registered; the group was accepted last cycle.
REQ-014 SHALL have ports tag0_o..tag3_o, output, TAG_LOG each: registered per-slot allocated tags.
REQ-015 SHALL have port tagValid_o, output, DISPATCH_WIDTH: registered; slot i carries a valid tag.
REQ-016 SHALL have port stallTag_o, output, 1: combinational; the head group is ready but free tags are insufficient.
REQ-017 SHALL have port freeCount_o, output, TAG_LOG+1: current number of free tags.
REQ-018 SHALL have port error_o, output, 1: sticky protocol error flag (see Configuration).

Function
REQ-019 SHALL keep the free tags in a circular FIFO of NUM_TAGS entries with head pointer, tail pointer and a count register of width TAG_LOG+1.
REQ-020 SHALL compute n = popcount(branchVector_i) and SHALL use n, never branchCount_i, for allocation.
REQ-021 SHALL accept a group when instBufferReady_i=1, stall_i=0, flush_i=0 and freeCount >= n; the accept condition is named alloc.
REQ-022 SHALL drive stallTag_o = instBufferReady_i & ~stall_i & (freeCount < n).
REQ-023 SHALL, on alloc, pop n tags from the head and assign them to branch slots in ascending slot order; non-branch slots get tag 0 with tagValid 0.
REQ-024 SHALL present tags, tagValid_o and groupValid_o=1 in the cycle after alloc (1-cycle latency); otherwise groupValid_o=0 and tagValid_o=0.
REQ-025 SHALL hold tagN_o at their previous values when no group is accepted.
REQ-026 SHALL, when resolveValid_i=1 and flush_i=0, write resolveTag_i at the tail and increment the tail.
REQ-027 SHALL update the count as count - (alloc ? n : 0) + (release ? 1 : 0) when alloc and release occur in the same cycle.
REQ-028 SHALL NOT make a tag released in cycle t allocatable before cycle t+1; freeCount in cycle t excludes it.
REQ-029 SHALL wrap head and tail modulo NUM_TAGS.
REQ-030 SHALL ignore a release while count = NUM_TAGS and SHALL leave the FIFO unchanged.
REQ-031 SHALL accept a group with n=0 regardless of freeCount.
REQ-032 SHALL, on flush_i, take priority over alloc and release: reinitialise the FIFO, set groupValid_o=0 and tagValid_o=0 next cycle.

Reset
REQ-033 SHALL, on reset (and on flush), load entry k with tag k, set head=0, tail=0 and count=NUM_TAGS.
REQ-034 SHALL reset to groupValid_o=0, tagValid_o=0, tag0_o..tag3_o=0, error_o=0; freeCount_o reads NUM_TAGS.
REQ-035 SHALL let reset override flush_i and all other inputs, including when asserted mid-allocation.

Configuration
REQ-036 SHALL, with macro CTRL_TAG_ALLOC_CHECK_EN defined, set error_o sticky (until reset) when a release occurs at count=NUM_TAGS, or when alloc occurs with branchCount_i != n.
REQ-037 SHALL, without CTRL_TAG_ALLOC_CHECK_EN, tie error_o to 0 and include no checking logic.

Verification
REQ-038 SHALL cover: reset, then a group with branchVector=4'b1010, ready=1 -> next cycle groupValid=1, tag1=0, tag3=1, tagValid=4'b1010, freeCount=6.
REQ-039 SHALL cover: freeCount=2, group with vector 4'b0111 -> stallTag_o=1, no pop; release one tag -> accepted the following cycle, freeCount=0.
REQ-040 SHALL cover: alloc of n=2 and release of tag 5 in the same cycle at freeCount=3 -> freeCount=2 next cycle; tag 5 not in that group.
REQ-041 SHALL cover: allocate 8 tags over 2 groups, release all 8, allocate again -> tags return in release order and pointers wrap to 0.
REQ-042 SHALL cover: flush_i together with alloc and release at freeCount=1 -> next cycle freeCount=8, groupValid=0, tags 0..7 reissued in order.
REQ-043 SHALL cover: with CTRL_TAG_ALLOC_CHECK_EN, a release at freeCount=8 -> error_o=1 and held until reset; without the macro -> error_o=0.
